// File: rtl/truth_table_scanner.sv
// truth_table_scanner
// Drives every input vector 0..2**N_IN-1 into a combinational block, waits
// SETTLE cycles for it to settle, samples its single output, and builds the
// captured truth table. The capture is compared bit-by-bit against a reference
// table latched at start; the mismatch count and a pass flag are reported
// together with a one-cycle done pulse.
module truth_table_scanner #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [(1<<N_IN)-1:0]   expected,
    output logic [N_IN-1:0]        dut_in,
    input  logic                   dut_y,
    output logic                   busy,
    output logic                   done,
    output logic [(1<<N_IN)-1:0]   table_out,
    output logic [N_IN:0]          mismatch_cnt,
    output logic                   pass
);

    localparam int TW = 1 << N_IN;
    // Settle counter only needs to hold SETTLE; keep at least one bit so the
    // SETTLE=0 build still elaborates cleanly.
    localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [SW-1:0]   SETTLE_LD = SW'(SETTLE);
    localparam logic [SW-1:0]   SETTLE_ONE = SW'(1);
    localparam logic [N_IN:0]   CNT_MAX = (N_IN + 1)'(TW);
    localparam logic [N_IN:0]   CNT_ONE = (N_IN + 1)'(1);
    localparam logic [N_IN-1:0] IDX_ONE = N_IN'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic [SW-1:0]     settle_q, settle_d;
    logic [TW-1:0]     exp_q, exp_d;
    logic [TW-1:0]     table_q, table_d;
    logic [N_IN:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              last_vec;
    logic              bit_miss;

    // The terminal-vector test is done on the current index, before any
    // increment, so idx never wraps back to 0 inside a scan.
    assign last_vec = &idx_q;
    assign bit_miss = (dut_y != exp_q[idx_q]);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (SETTLE > 0) state_d = S_WAIT;
                    else            state_d = S_CAPTURE;
                end
            end
            S_WAIT: begin
                if (settle_q == SETTLE_ONE) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (last_vec) begin
                    state_d = S_DONE;
                end else if (SETTLE > 0) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_CAPTURE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next-values for each state
    always_comb begin
        idx_d    = idx_q;
        settle_d = settle_q;
        exp_d    = exp_q;
        table_d  = table_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    exp_d    = expected;
                    table_d  = '0;
                    cnt_d    = '0;
                    pass_d   = 1'b0;
                    idx_d    = '0;
                    busy_d   = 1'b1;
                    settle_d = SETTLE_LD;
                end
            end
            S_WAIT: begin
                settle_d = settle_q - SETTLE_ONE;
            end
            S_CAPTURE: begin
                table_d[idx_q] = dut_y;
                if (bit_miss && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
                if (last_vec) begin
                    // pass is taken from the updated count so it already
                    // includes the final vector when done is seen.
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    pass_d = (cnt_d == '0);
                end else begin
                    idx_d    = idx_q + IDX_ONE;
                    settle_d = SETTLE_LD;
                end
            end
            S_DONE: begin
                // Return the driven vector to 0 for the idle period.
                idx_d = '0;
            end
            default: begin
                idx_d = '0;
            end
        endcase
    end

    // Datapath and output registers; everything clears on reset so no
    // partial scan result survives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q    <= '0;
            settle_q <= '0;
            exp_q    <= '0;
            table_q  <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            settle_q <= settle_d;
            exp_q    <= exp_d;
            table_q  <= table_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    assign dut_in       = idx_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign table_out    = table_q;
    assign mismatch_cnt = cnt_q;
    assign pass         = pass_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: three builds (SETTLE=1, 0, 3) scan the same
// behavioural gate network (AND, XOR or inverted XOR of the four inputs).
module tb_truth_table_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] expected;
    logic [1:0]  mode;

    logic [3:0]  din1, din0, din3;
    logic        y1, y0, y3;
    logic        busy1, busy0, busy3;
    logic        done1, done0, done3;
    logic [15:0] tab1, tab0, tab3;
    logic [4:0]  cnt1, cnt0, cnt3;
    logic        pass1, pass0, pass3;

    int n_checks = 0;
    int n_errors = 0;

    int d1, d0, d3;
    int np1;
    int q1[$];
    int q0[$];
    int q3[$];

    always #5 clk = ~clk;

    // Gate network under test: 0 = AND, 1 = XOR, 2 = inverted XOR
    function automatic logic model_y(input logic [1:0] m, input logic [3:0] x);
        case (m)
            2'd0:    return &x;
            2'd1:    return ^x;
            default: return ~^x;
        endcase
    endfunction

    assign y1 = model_y(mode, din1);
    assign y0 = model_y(mode, din0);
    assign y3 = model_y(mode, din3);

    truth_table_scanner #(.N_IN(4), .SETTLE(1)) u_s1 (
        .clk(clk), .rst(rst), .start(start), .expected(expected),
        .dut_in(din1), .dut_y(y1), .busy(busy1), .done(done1),
        .table_out(tab1), .mismatch_cnt(cnt1), .pass(pass1)
    );

    truth_table_scanner #(.N_IN(4), .SETTLE(0)) u_s0 (
        .clk(clk), .rst(rst), .start(start), .expected(expected),
        .dut_in(din0), .dut_y(y0), .busy(busy0), .done(done0),
        .table_out(tab0), .mismatch_cnt(cnt0), .pass(pass0)
    );

    truth_table_scanner #(.N_IN(4), .SETTLE(3)) u_s3 (
        .clk(clk), .rst(rst), .start(start), .expected(expected),
        .dut_in(din3), .dut_y(y3), .busy(busy3), .done(done3),
        .table_out(tab3), .mismatch_cnt(cnt3), .pass(pass3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Pulse start with reference table e, then watch all three builds until
    // each has signalled done (bounded), recording done cycle and the dut_in
    // value seen in every busy cycle. Cycle c is the c-th cycle after the
    // start edge.
    task automatic run_scan(input logic [15:0] e);
        d1 = 0; d0 = 0; d3 = 0; np1 = 0;
        q1.delete(); q0.delete(); q3.delete();
        @(negedge clk);
        expected = e;
        start    = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 120; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (busy1) q1.push_back(int'(din1));
            if (busy0) q0.push_back(int'(din0));
            if (busy3) q3.push_back(int'(din3));
            if (done1) np1++;
            if (done1 && d1 == 0) d1 = c;
            if (done0 && d0 == 0) d0 = c;
            if (done3 && d3 == 0) d3 = c;
            if (d1 != 0 && d0 != 0 && d3 != 0) break;
        end
    endtask

    task automatic check_seq(input string name, input int q[$], input int per);
        int bad;
        bad = 0;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i] != i / per) bad++;
        end
        check({name, "_len"}, q.size(), 16 * per);
        check({name, "_bad"}, bad, 0);
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] exp_tab;
        logic [15:0] want_tab;
        logic [4:0]  want_cnt;
        logic        want_pass;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int cyc_seen;
        int busy_hits;
        int done_hits;
        logic [4:0] cnt_at_done;
        logic       pass_at_done;

        vecs[0] = '{mode: 2'd0, exp_tab: 16'h8000, want_tab: 16'h8000, want_cnt: 5'd0,  want_pass: 1'b1};
        vecs[1] = '{mode: 2'd1, exp_tab: 16'h6996, want_tab: 16'h6996, want_cnt: 5'd0,  want_pass: 1'b1};
        vecs[2] = '{mode: 2'd1, exp_tab: 16'h6997, want_tab: 16'h6996, want_cnt: 5'd1,  want_pass: 1'b0};
        vecs[3] = '{mode: 2'd2, exp_tab: 16'h6996, want_tab: 16'h9669, want_cnt: 5'd16, want_pass: 1'b0};

        rst = 1'b1; start = 1'b0; expected = 16'h0; mode = 2'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_dut_in", din1, 0);
        check("rst_busy",   busy1, 0);
        check("rst_done",   done1, 0);
        check("rst_table",  tab1, 0);
        check("rst_cnt",    cnt1, 0);
        check("rst_pass",   pass1, 0);

        for (int v = 0; v < 4; v++) begin
            mode = vecs[v].mode;
            run_scan(vecs[v].exp_tab);
            check($sformatf("v%0d_done_cyc_s1", v), d1, 33);
            check($sformatf("v%0d_done_cyc_s0", v), d0, 17);
            check($sformatf("v%0d_done_cyc_s3", v), d3, 65);
            check($sformatf("v%0d_done_pulses", v), np1, 1);
            check($sformatf("v%0d_busy_after", v), busy1, 0);
            check($sformatf("v%0d_table_s1", v), tab1, vecs[v].want_tab);
            check($sformatf("v%0d_table_s0", v), tab0, vecs[v].want_tab);
            check($sformatf("v%0d_table_s3", v), tab3, vecs[v].want_tab);
            check($sformatf("v%0d_cnt_s1", v), cnt1, vecs[v].want_cnt);
            check($sformatf("v%0d_cnt_s0", v), cnt0, vecs[v].want_cnt);
            check($sformatf("v%0d_cnt_s3", v), cnt3, vecs[v].want_cnt);
            check($sformatf("v%0d_pass_s1", v), pass1, vecs[v].want_pass);
            check($sformatf("v%0d_pass_s0", v), pass0, vecs[v].want_pass);
            check($sformatf("v%0d_pass_s3", v), pass3, vecs[v].want_pass);
            check_seq($sformatf("v%0d_seq_s1", v), q1, 2);
            check_seq($sformatf("v%0d_seq_s0", v), q0, 1);
            check_seq($sformatf("v%0d_seq_s3", v), q3, 4);
            check($sformatf("v%0d_idle_dut_in", v), din1, 0);
        end

        // Asynchronous reset in the middle of a scan, at vector 7
        mode = 2'd1;
        @(negedge clk);
        expected = 16'h6996;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 40 && din1 != 4'd7; c++) @(negedge clk);
        check("mid_reach_vec7", din1, 7);
        check("mid_busy_before", busy1, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_dut_in", din1, 0);
        check("mid_rst_busy",   busy1, 0);
        check("mid_rst_done",   done1, 0);
        check("mid_rst_table",  tab1, 0);
        check("mid_rst_cnt",    cnt1, 0);
        check("mid_rst_pass",   pass1, 0);
        check("mid_rst_busy3",  busy3, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_idle_busy", busy1, 0);
        run_scan(16'h6996);
        check("after_rst_done_cyc", d1, 33);
        check("after_rst_table", tab1, 16'h6996);
        check("after_rst_cnt",   cnt1, 0);
        check("after_rst_pass",  pass1, 1);

        // start held high, then toggled during busy; expected changed mid-scan
        mode = 2'd1;
        repeat (5) @(negedge clk);
        expected = 16'h6996;
        start    = 1'b1;
        @(posedge clk);
        cyc_seen = 0; done_hits = 0; cnt_at_done = '1; pass_at_done = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (c == 5) expected = 16'h0000;
            if (c >= 20 && c < 30) start = ~start;
            if (c == 30) start = 1'b0;
            if (done1) begin
                done_hits++;
                if (cyc_seen == 0) begin
                    cyc_seen     = c;
                    cnt_at_done  = cnt1;
                    pass_at_done = pass1;
                end
            end
        end
        check("hold_done_count", done_hits, 1);
        check("hold_done_cyc",   cyc_seen, 33);
        check("hold_cnt",        cnt_at_done, 0);
        check("hold_pass",       pass_at_done, 1);
        check("hold_table",      tab1, 16'h6996);
        repeat (80) @(negedge clk);

        // start asserted only in the DONE cycle must be ignored
        mode = 2'd0;
        @(negedge clk);
        expected = 16'h8000;
        start    = 1'b1;
        @(posedge clk);
        cyc_seen = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (done1) begin
                cyc_seen = c;
                start    = 1'b1;
                break;
            end
        end
        check("donecyc_start_seen", cyc_seen, 33);
        busy_hits = 0;
        @(negedge clk);
        start = 1'b0;
        if (busy1) busy_hits++;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (busy1) busy_hits++;
        end
        check("donecyc_start_ignored", busy_hits, 0);
        check("donecyc_table", tab1, 16'h8000);
        check("donecyc_pass",  pass1, 1);
        repeat (80) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
